// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters, with a single operation in flight.
// Issue-to-response time is ALU_LAT+1 cycles. Define ALU_ARB_ILLEGAL_TRAP_EN to answer undecodable ops with 32'hFFFF_FFFF.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op,
  input  logic [11:0] req_funct,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  output logic [5:0]  alu_funct,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(ALU_LAT - 1);

  function automatic logic [5:0] decode(input logic [1:0] op, input logic [5:0] funct);
    logic [5:0] d;
    d = 6'b000000;
    case (op)
      2'b00: d = 6'b001001;
      2'b01: d = 6'b001010;
      2'b11: d = 6'b101010;
      default: begin
        case (funct)
          6'b001011: d = 6'b001001;
          6'b001101: d = 6'b001010;
          6'b100110: d = 6'b100001;
          6'b110110: d = 6'b110101;
          default:   d = 6'b000000;
        endcase
      end
    endcase
    return d;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_own;
  logic [2:0]  r_cnt;
  logic [5:0]  r_alu_funct;
  logic [31:0] r_alu_src1;
  logic [31:0] r_alu_src2;
  logic        r_rsp_id;
  logic [31:0] r_rsp_data;

  logic        w_gnt;
  logic        w_accept;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [5:0]  w_dec;
  logic        w_cnt_done;
  logic        w_load;
  logic        w_capture;
  logic        w_trap;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_gnt = 1'b0;
    if (req_valid == 2'b11) begin
      w_gnt = ~r_last;
    end else if (req_valid == 2'b10) begin
      w_gnt = 1'b1;
    end
  end

  assign w_accept   = rst_n && (r_state == S_IDLE) && (req_valid != 2'b00);
  assign req_ready  = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

  assign w_op       = w_gnt ? req_op[3:2]      : req_op[1:0];
  assign w_funct    = w_gnt ? req_funct[11:6]  : req_funct[5:0];
  assign w_src1     = w_gnt ? req_src1[63:32]  : req_src1[31:0];
  assign w_src2     = w_gnt ? req_src2[63:32]  : req_src2[31:0];
  assign w_dec      = decode(w_op, w_funct);
  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_trap    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef ALU_ARB_ILLEGAL_TRAP_EN
          if (w_dec == 6'b000000) begin
            w_next = S_RESP;
            w_trap = 1'b1;
          end else begin
            w_next = S_EXEC;
            w_load = 1'b1;
          end
`else
          w_next = S_EXEC;
          w_load = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        if (w_cnt_done) begin
          w_next    = S_RESP;
          w_capture = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_own       <= 1'b0;
      r_cnt       <= 3'd0;
      r_alu_funct <= 6'd0;
      r_alu_src1  <= 32'd0;
      r_alu_src2  <= 32'd0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_last <= w_gnt;
        r_own  <= w_gnt;
      end
      if (w_load) begin
        r_alu_funct <= w_dec;
        r_alu_src1  <= w_src1;
        r_alu_src2  <= w_src2;
        r_cnt       <= 3'd0;
      end else if (w_capture) begin
        r_cnt <= 3'd0;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_capture) begin
        r_rsp_data <= alu_result;
        r_rsp_id   <= r_own;
      end
      // A trapped op never reaches the ALU, so the alu_* registers keep their last values.
      if (w_trap) begin
        r_rsp_data <= 32'hFFFF_FFFF;
        r_rsp_id   <= w_gnt;
      end
    end
  end

  assign alu_funct = r_alu_funct;
  assign alu_src1  = r_alu_src1;
  assign alu_src2  = r_alu_src2;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one ALU_LAT=1 instance with a response scoreboard, plus an ALU_LAT=3 instance for reset and latency.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [3:0]  req_op;
  logic [11:0] req_funct;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic        rsp_ready;

  logic [1:0]  rdy1, rdy3;
  logic [5:0]  funct1, funct3;
  logic [31:0] s1_1, s2_1, s1_3, s2_3;
  logic [31:0] res1, res3;
  logic        rv1, rv3, rid1, rid3;
  logic [31:0] rd1, rd3;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [5:0] dec(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 6'b001001;
    if (op == 2'b01) return 6'b001010;
    if (op == 2'b11) return 6'b101010;
    if (f == 6'b001011) return 6'b001001;
    if (f == 6'b001101) return 6'b001010;
    if (f == 6'b100110) return 6'b100001;
    if (f == 6'b110110) return 6'b110101;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] alu_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'b001001: return a + b;
      6'b001010: return a - b;
      6'b101010: return {31'd0, ($signed(a) < $signed(b))};
      6'b100001: return a + b;
      6'b110101: return a ^ b;
      default:   return a | b;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input logic [1:0] op, input logic [5:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_ARB_ILLEGAL_TRAP_EN
    if (dec(op, f) == 6'b000000) return 32'hFFFF_FFFF;
`endif
    return alu_model(dec(op, f), a, b);
  endfunction

  assign res1 = alu_model(funct1, s1_1, s2_1);
  assign res3 = alu_model(funct3, s1_3, s2_3);

  alu_arbiter #(.ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_op(req_op), .req_funct(req_funct), .req_src1(req_src1), .req_src2(req_src2),
    .alu_funct(funct1), .alu_src1(s1_1), .alu_src2(s2_1), .alu_result(res1),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_id(rid1), .rsp_data(rd1)
  );

  alu_arbiter #(.ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3),
    .req_op(req_op), .req_funct(req_funct), .req_src1(req_src1), .req_src2(req_src2),
    .alu_funct(funct3), .alu_src1(s1_3), .alu_src2(s2_3), .alu_result(res3),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_id(rid3), .rsp_data(rd3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    if (idx == 0) begin
      req_op[1:0] = op; req_funct[5:0] = f; req_src1[31:0] = a; req_src2[31:0] = b;
    end else begin
      req_op[3:2] = op; req_funct[11:6] = f; req_src1[63:32] = a; req_src2[63:32] = b;
    end
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    while (rdy1 == 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
  endtask

  // Every accepted response of the ALU_LAT=1 instance is checked against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rv1 && rsp_ready) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL rsp_unexpected observed id=%0d data=%0h expected=none", rid1, rd1);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", {31'd0, rid1}, {31'd0, e.id});
        chk("rsp_data", rd1, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] t_op  [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10};
  logic [5:0] t_f   [8] = '{6'b001011, 6'b001101, 6'b100110, 6'b110110, 6'b000000,
                            6'b111000, 6'b000101, 6'b111111};
  logic [5:0] t_exp [8] = '{6'b001001, 6'b001010, 6'b100001, 6'b110101, 6'b000000,
                            6'b001010, 6'b101010, 6'b000000};

  initial begin
    int w;
    int e;
    logic [31:0] a, b;

    rst_n = 1'b0; req_valid = 2'b11; req_op = '0; req_funct = '0;
    req_src1 = '0; req_src2 = '0; rsp_ready = 1'b0;
    #13;
    chk("rst_req_ready", {30'd0, rdy1}, 32'd0);
    chk("rst_req_ready3", {30'd0, rdy3}, 32'd0);
    chk("rst_alu_funct", {26'd0, funct1}, 32'd0);
    chk("rst_alu_src1", s1_1, 32'd0);
    chk("rst_alu_src2", s2_1, 32'd0);
    chk("rst_rsp_valid", {31'd0, rv1}, 32'd0);
    chk("rst_rsp_id", {31'd0, rid1}, 32'd0);
    chk("rst_rsp_data", rd1, 32'd0);
    req_valid = 2'b00;
    #10 rst_n = 1'b1;
    tick();

    // Basic issue with ALU_LAT=1: accept, operands on the ALU next cycle, response the cycle after.
    set_req(0, 2'b00, 6'd0, 32'd5, 32'd7);
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    chk("t1_req_ready", {30'd0, rdy1}, 32'h1);
    sb.push_back('{id: 1'b0, data: 32'd12});
    tick();
    req_valid = 2'b00;
    #1;
    chk("t1_alu_funct", {26'd0, funct1}, 32'b001001);
    chk("t1_alu_src1", s1_1, 32'd5);
    chk("t1_alu_src2", s2_1, 32'd7);
    chk("t1_rsp_valid_exec", {31'd0, rv1}, 32'd0);
    tick();
    chk("t1_rsp_valid", {31'd0, rv1}, 32'd1);
    chk("t1_rsp_id", {31'd0, rid1}, 32'd0);
    chk("t1_rsp_data", rd1, 32'd12);
    tick();
    chk("t1_rsp_valid_drop", {31'd0, rv1}, 32'd0);

    // Round-robin with both requesting from a fresh reset, plus issue spacing of ALU_LAT+2.
    rst_n = 1'b0; #1 rst_n = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 2'b00, 6'd0, 32'(100 + k), 32'(10 * k));
      set_req(1, 2'b01, 6'd0, 32'(50 + k), 32'(3 + k));
      #1;
      wait_grant(w);
      e = k % 2;
      chk("rr_grant", {30'd0, rdy1}, 32'(1) << e);
      chk("rr_spacing", 32'(w), (k == 0) ? 32'd0 : 32'd2);
      if (e == 0) sb.push_back('{id: 1'b0, data: 32'(100 + k) + 32'(10 * k)});
      else        sb.push_back('{id: 1'b1, data: 32'(50 + k) - 32'(3 + k)});
      tick();
    end
    req_valid = 2'b00;
    tick();
    tick();

    // Decode table through requester 0 only (a lone requester wins regardless of pointer).
    for (int i = 0; i < 8; i++) begin
      a = 32'h1000 + 32'(i * 7);
      b = 32'h30 + 32'(i);
`ifdef ALU_ARB_ILLEGAL_TRAP_EN
      if (t_exp[i] != 6'b000000) begin
`else
      begin
`endif
        set_req(0, t_op[i], t_f[i], a, b);
        req_valid = 2'b01;
        #1;
        wait_grant(w);
        chk("dec_req_ready", {30'd0, rdy1}, 32'h1);
        sb.push_back('{id: 1'b0, data: exp_data(t_op[i], t_f[i], a, b)});
        tick();
        req_valid = 2'b00;
        chk("dec_alu_funct", {26'd0, funct1}, {26'd0, t_exp[i]});
        chk("dec_alu_src1", s1_1, a);
        tick();
        tick();
      end
    end

    // Response stall: outputs hold and nothing is granted while rsp_ready is low.
    rsp_ready = 1'b0;
    set_req(0, 2'b11, 6'd0, 32'hFFFF_FFF0, 32'd5);
    set_req(1, 2'b00, 6'd0, 32'd9, 32'd4);
    req_valid = 2'b01;
    #1;
    wait_grant(w);
    chk("stall_req_ready", {30'd0, rdy1}, 32'h1);
    sb.push_back('{id: 1'b0, data: 32'd1});
    tick();
    req_valid = 2'b11;
    tick();
    for (int j = 0; j < 5; j++) begin
      chk("stall_rsp_valid", {31'd0, rv1}, 32'd1);
      chk("stall_rsp_data", rd1, 32'd1);
      chk("stall_rsp_id", {31'd0, rid1}, 32'd0);
      chk("stall_req_ready", {30'd0, rdy1}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall_release_valid", {31'd0, rv1}, 32'd0);
    chk("stall_next_grant", {30'd0, rdy1}, 32'h2);
    sb.push_back('{id: 1'b1, data: 32'd13});
    tick();
    req_valid = 2'b00;
    tick();
    tick();

    // ALU_LAT=3 instance: reset in the middle of EXEC abandons the op.
    rst_n = 1'b0; #1 rst_n = 1'b1;
    set_req(0, 2'b00, 6'd0, 32'd21, 32'd22);
    set_req(1, 2'b01, 6'd0, 32'd8, 32'd2);
    req_valid = 2'b01;
    #1;
    chk("l3_req_ready", {30'd0, rdy3}, 32'h1);
    sb.push_back('{id: 1'b0, data: 32'd43});
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("l3_alu_funct_exec", {26'd0, funct3}, 32'b001001);
    chk("l3_rsp_valid_exec", {31'd0, rv3}, 32'd0);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("l3_rst_alu_funct", {26'd0, funct3}, 32'd0);
    chk("l3_rst_alu_src1", s1_3, 32'd0);
    chk("l3_rst_alu_src2", s2_3, 32'd0);
    chk("l3_rst_rsp_valid", {31'd0, rv3}, 32'd0);
    chk("l3_rst_rsp_data", rd3, 32'd0);
    chk("l3_rst_req_ready", {30'd0, rdy3}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("l3_first_grant", {30'd0, rdy3}, 32'h1);
    chk("l1_first_grant", {30'd0, rdy1}, 32'h1);
    sb.push_back('{id: 1'b0, data: 32'd43});
    tick();
    req_valid = 2'b00;
    w = 0;
    while (!rv3 && w < 10) begin
      tick();
      w++;
    end
    chk("l3_latency", 32'(w), 32'd3);
    chk("l3_rsp_data", rd3, 32'd43);
    chk("l3_rsp_id", {31'd0, rid3}, 32'd0);
    tick();

`ifdef ALU_ARB_ILLEGAL_TRAP_EN
    // Undecodable op skips the ALU; the alu_* outputs keep the previous op's values.
    set_req(0, 2'b10, 6'b111111, 32'd3, 32'd4);
    req_valid = 2'b01;
    #1;
    wait_grant(w);
    sb.push_back('{id: 1'b0, data: 32'hFFFF_FFFF});
    tick();
    req_valid = 2'b00;
    chk("trap_rsp_valid", {31'd0, rv1}, 32'd1);
    chk("trap_rsp_data", rd1, 32'hFFFF_FFFF);
    chk("trap_alu_funct", {26'd0, funct1}, 32'b001001);
    chk("trap_alu_src1", s1_1, 32'd21);
    tick();
`endif

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: ALU_LAT, default 1, cycles from operand/funct issue to valid alu_result (legal 1..4).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_valid  input  2  bit i = requester i has an operation pending.
REQ-005 SHALL have port: req_ready  output  2  bit i = requester i's operation accepted this cycle.
REQ-006 SHALL have port: req_op  input  4  ALU_op per requester, [1:0] = req0, [3:2] = req1.
REQ-007 SHALL have port: req_funct  input  12  instruction funct per requester, [5:0] = req0, [11:6] = req1.
REQ-008 SHALL have port: req_src1  input  64  operand A per requester, [31:0] = req0.
REQ-009 SHALL have port: req_src2  input  64  operand B per requester, [31:0] = req0.
REQ-010 SHALL have port: alu_funct  output  6  registered ALU function code.
REQ-011 SHALL have port: alu_src1  output  32  registered operand A to the ALU.
REQ-012 SHALL have port: alu_src2  output  32  registered operand B to the ALU.
REQ-013 SHALL have port: alu_result  input  32  ALU result.
REQ-014 SHALL have port: rsp_valid  output  1  response held valid.
REQ-015 SHALL have port: rsp_ready  input  1  consumer accepts response.
REQ-016 SHALL have port: rsp_id  output  1  index of requester owning the response.
REQ-017 SHALL have port: rsp_data  output  32  captured ALU result.

Function
REQ-018 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight.
REQ-019 In IDLE with any req_valid, SHALL assert req_ready for exactly one granted index (combinational), latch its op/funct/operands at that edge, enter EXEC.
REQ-020 Arbitration SHALL be round-robin: on tie, grant the index not granted last; after reset req0 wins the first tie; a single valid requester is granted regardless.
REQ-021 Decode SHALL be: op 00 -> 001001; 01 -> 001010; 11 -> 101010; 10 with funct 001011 -> 001001, 001101 -> 001010, 100110 -> 100001, 110110 -> 110101, any other funct -> 000000.
REQ-022 In EXEC, alu_funct/alu_src1/alu_src2 SHALL hold decoded values for exactly ALU_LAT cycles (counter), then alu_result SHALL be captured into rsp_data, rsp_id set, and state enters RESP.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_id stable until the cycle rsp_ready=1; that edge returns to IDLE with rsp_valid=0.
REQ-024 req_ready SHALL be 0 outside IDLE; a req_valid arriving in EXEC/RESP waits, and its fields SHALL not be sampled until grant.
REQ-025 Minimum issue-to-issue spacing SHALL be ALU_LAT+2 cycles (rsp_ready held high).
REQ-026 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, req_ready=0, alu_funct=0, alu_src1=0, alu_src2=0, rsp_valid=0, rsp_id=0, rsp_data=0, latency counter=0, round-robin pointer to "last=req1".
REQ-028 Reset during EXEC or RESP SHALL abandon the operation with no response; first grant after release follows REQ-020.

Configuration
REQ-029 Macro ALU_ARB_ILLEGAL_TRAP_EN: when defined, a decode yielding 000000 SHALL skip EXEC, go straight to RESP with rsp_data=32'hFFFF_FFFF and alu_* outputs unchanged; when undefined, funct 000000 SHALL be issued to the ALU through the normal EXEC path.

Verification
REQ-030 Reset release, req_valid=2'b01, op=00, src1=5, src2=7, alu_result model=12, ALU_LAT=1 -> req_ready=01 cycle 0, alu_funct=001001 cycle 1, rsp_valid=1 rsp_id=0 rsp_data=12 cycle 2.
REQ-031 req_valid=2'b11 held continuously, rsp_ready=1 -> grants alternate req0, req1, req0; rsp_id sequence 0,1,0.
REQ-032 op=10 with funct 001011/001101/100110/110110/000000 -> alu_funct 001001/001010/100001/110101/000000 (trap undefined).
REQ-033 RESP with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data, rsp_id unchanged, req_ready=00 despite req_valid=11.
REQ-034 rst_n pulsed low mid-EXEC with ALU_LAT=3 -> all outputs 0 asynchronously, no rsp_valid afterward for that op.
REQ-035 ALU_ARB_ILLEGAL_TRAP_EN defined, op=10 funct=111111 -> rsp_valid one cycle after accept, rsp_data=FFFF_FFFF, alu_funct unchanged.
